prog_updown_counter: RTL and testbench
======================================

PROG_UPDOWN_COUNTER -- requirements
Module: prog_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits, legal range 2..32.
REQ-002 Parameter RST_VAL, default {WIDTH{1'b1}}, value loaded into count on reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; advances count one step per cycle when high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 limit  input  WIDTH  upper bound; legal count range is 0..limit inclusive.
REQ-010 sat  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-011 oneshot  input  1  1 = halt at first boundary hit, overriding sat.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 tc  output  1  registered terminal-count flag; high for the cycle after a boundary event.
REQ-014 halted  output  1  registered; high while the FSM is in HALT.

Function
REQ-015 Priority each edge SHALL be rst > load > en; all inputs sampled every edge.
REQ-016 FSM SHALL have two states, RUN and HALT; halted = (state == HALT).
REQ-017 load SHALL set count to min(load_val, limit), tc to 0 and state to RUN, from either state.
REQ-018 In HALT, count SHALL hold, tc SHALL be 0, en/up/sat SHALL be ignored.
REQ-019 In RUN with en = 0, count SHALL hold and tc SHALL be 0.
REQ-020 In RUN with en = 1 and count > limit, count SHALL become limit and tc SHALL be 0 (clamp after limit lowered).
REQ-021 Down step, count > 0: count SHALL become count-1, tc = 0.
REQ-022 Down step, count == 0 (boundary): tc = 1; oneshot -> count holds 0, state HALT; else sat -> count holds 0; else count SHALL wrap to limit.
REQ-023 Up step, count < limit: count SHALL become count+1, tc = 0.
REQ-024 Up step, count == limit (boundary): tc = 1; oneshot -> count holds limit, state HALT; else sat -> count holds limit; else count SHALL wrap to 0.
REQ-025 In saturate mode tc SHALL reassert on every enabled cycle spent at the boundary.
REQ-026 limit == 0: count SHALL stay 0 and every enabled RUN cycle SHALL be a boundary event in either direction.
REQ-027 Direction change SHALL take effect on the same edge it is sampled; no pipeline latency on any path (one-cycle register update).
REQ-028 Arithmetic SHALL be modulo WIDTH internally with no carry out; count SHALL never exceed max(limit, RST_VAL).
REQ-029 Simultaneous load and en SHALL perform load only; simultaneous load and a boundary SHALL give tc = 0.

Reset
REQ-030 rst SHALL force count = RST_VAL, tc = 0, halted = 0, state RUN on the next edge, overriding load and en.
REQ-031 rst mid-count or in HALT SHALL behave identically to rst from power-up; no other state survives reset.
REQ-032 RST_VAL above the current limit SHALL be held as-is until the first enabled step clamps it per REQ-020.

Verification (WIDTH = 4, defaults)
REQ-033 rst = 1 two cycles then en = 1, up = 0, limit = 15, sat = 0 -> count 15,14..0,15; tc high exactly on the cycle count goes 0 -> 15.
REQ-034 load = 1, load_val = 3, limit = 9, up = 1, sat = 0 -> count 3..9,0,1; tc once at 9 -> 0; load_val = 12 -> count = 9.
REQ-035 limit = 5, up = 1, sat = 1 from 4 for 4 cycles -> count 5,5,5,5; tc = 0,1,1,1.
REQ-036 oneshot = 1, load 2, up = 0, en = 1 -> count 1,0,0; halted rises with tc on the 2 -> 0 step... hold; further en ignored; load 7 -> halted = 0, count = 7.
REQ-037 Count at 12, limit changed to 6, en = 1 -> count = 6, tc = 0; next down step -> 5.
REQ-038 rst asserted in HALT with load = 1 and en = 1 the same edge -> count = 15, halted = 0, tc = 0.

Source files
------------

// File: rtl/prog_updown_counter_if.sv
// Control and status bundle for prog_updown_counter.
// master drives the controls and observes the counter; slave is the counter itself.
interface prog_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             sat;
  logic             oneshot;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             halted;

  modport master (
    output en, up, load, load_val, limit, sat, oneshot,
    input  count, tc, halted
  );

  modport slave (
    input  en, up, load, load_val, limit, sat, oneshot,
    output count, tc, halted
  );
endinterface

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter over 0..limit with wrap, saturate and one-shot halt modes.
// All outputs are registered; rst is synchronous and active-high.
module prog_updown_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  prog_updown_counter_if.slave   bus
);

  typedef enum logic {StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             at_top, at_bottom;

  assign at_top    = (count_q == bus.limit);
  assign at_bottom = (count_q == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (rst) begin
      state_d = StRun;
      count_d = RST_VAL;
    end else if (bus.load) begin
      state_d = StRun;
      count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
    end else if (state_q == StRun && bus.en) begin
      if (count_q > bus.limit) begin
        // limit was lowered underneath us: clamp without flagging a boundary
        count_d = bus.limit;
      end else if (bus.up) begin
        if (at_top) begin
          tc_d = 1'b1;
          if (bus.oneshot) begin
            state_d = StHalt;
          end else if (!bus.sat) begin
            count_d = '0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_bottom) begin
          tc_d = 1'b1;
          if (bus.oneshot) begin
            state_d = StHalt;
          end else if (!bus.sat) begin
            count_d = bus.limit;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    count_q <= count_d;
    tc_q    <= tc_d;
  end

  assign bus.count  = count_q;
  assign bus.tc     = tc_q;
  assign bus.halted = (state_q == StHalt);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Directed scoreboard bench for prog_updown_counter (WIDTH = 4, default RST_VAL).
// Stimulus pushes hand-computed expectations; a monitor pops one per clock and compares.
module tb_prog_updown_counter;

  logic clk;
  logic rst;

  prog_updown_counter_if #(.WIDTH(4)) bus ();

  prog_updown_counter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] exp_count_q[$];
  logic       exp_tc_q[$];
  logic       exp_halt_q[$];
  string      name_q[$];

  int checks;
  int errors;

  // Expectation for the edge following the current negedge, then advance one cycle.
  task automatic chk(input logic [3:0] c, input logic t, input logic h, input string name);
    exp_count_q.push_back(c);
    exp_tc_q.push_back(t);
    exp_halt_q.push_back(h);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [3:0] ec;
    logic       et, eh;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_count_q.size() > 0) begin
        ec = exp_count_q.pop_front();
        et = exp_tc_q.pop_front();
        eh = exp_halt_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (bus.count !== ec || bus.tc !== et || bus.halted !== eh) begin
          errors++;
          $display("FAIL %s: got count=%0d tc=%b halted=%b, want count=%0d tc=%b halted=%b",
                   nm, bus.count, bus.tc, bus.halted, ec, et, eh);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin : stimulus
    checks = 0;
    errors = 0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.up       = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
    bus.limit    = 4'd15;
    bus.sat      = 1'b0;
    bus.oneshot  = 1'b0;
    @(negedge clk);

    // Reset two cycles, then free-running down count with wrap
    chk(4'd15, 1'b0, 1'b0, "reset0");
    chk(4'd15, 1'b0, 1'b0, "reset1");
    rst    = 1'b0;
    bus.en = 1'b1;
    for (int i = 14; i >= 0; i--) chk(4'(i), 1'b0, 1'b0, "down");
    chk(4'd15, 1'b1, 1'b0, "down_wrap");
    chk(4'd14, 1'b0, 1'b0, "down_after_wrap");

    // Load 3 with limit 9, count up with wrap
    bus.load = 1'b1; bus.load_val = 4'd3; bus.limit = 4'd9; bus.up = 1'b1;
    chk(4'd3, 1'b0, 1'b0, "load3");
    bus.load = 1'b0;
    for (int i = 4; i <= 9; i++) chk(4'(i), 1'b0, 1'b0, "up");
    chk(4'd0, 1'b1, 1'b0, "up_wrap");
    chk(4'd1, 1'b0, 1'b0, "up_after_wrap");
    bus.load = 1'b1; bus.load_val = 4'd12;
    chk(4'd9, 1'b0, 1'b0, "load_clamp");

    // Saturate at limit 5
    bus.load_val = 4'd4; bus.limit = 4'd5; bus.sat = 1'b1;
    chk(4'd4, 1'b0, 1'b0, "load4");
    bus.load = 1'b0;
    chk(4'd5, 1'b0, 1'b0, "sat0");
    chk(4'd5, 1'b1, 1'b0, "sat1");
    chk(4'd5, 1'b1, 1'b0, "sat2");
    chk(4'd5, 1'b1, 1'b0, "sat3");
    bus.en = 1'b0;
    chk(4'd5, 1'b0, 1'b0, "en_off_hold");
    bus.en = 1'b1; bus.load = 1'b1; bus.load_val = 4'd5;
    chk(4'd5, 1'b0, 1'b0, "load_at_boundary");
    bus.load = 1'b0;

    // One-shot down, halts at 0 and ignores en/up
    bus.sat = 1'b0; bus.oneshot = 1'b1; bus.load = 1'b1; bus.load_val = 4'd2; bus.up = 1'b0;
    chk(4'd2, 1'b0, 1'b0, "os_load2");
    bus.load = 1'b0;
    chk(4'd1, 1'b0, 1'b0, "os_down1");
    chk(4'd0, 1'b0, 1'b0, "os_down0");
    chk(4'd0, 1'b1, 1'b1, "os_halt");
    chk(4'd0, 1'b0, 1'b1, "os_hold");
    bus.up = 1'b1; bus.sat = 1'b1;
    chk(4'd0, 1'b0, 1'b1, "os_ignore");
    bus.limit = 4'd9; bus.load = 1'b1; bus.load_val = 4'd7; bus.sat = 1'b0;
    chk(4'd7, 1'b0, 1'b0, "os_reload7");
    bus.load = 1'b0;
    chk(4'd8, 1'b0, 1'b0, "os_up8");
    chk(4'd9, 1'b0, 1'b0, "os_up9");
    chk(4'd9, 1'b1, 1'b1, "os_halt_top");

    // Reset in HALT beats load and en
    rst = 1'b1; bus.load = 1'b1; bus.load_val = 4'd3;
    chk(4'd15, 1'b0, 1'b0, "rst_in_halt");
    rst = 1'b0; bus.load = 1'b0; bus.oneshot = 1'b0;

    // RST_VAL above limit holds until an enabled step clamps it
    bus.limit = 4'd6; bus.en = 1'b0;
    chk(4'd15, 1'b0, 1'b0, "rstval_hold");
    bus.en = 1'b1;
    chk(4'd6, 1'b0, 1'b0, "rstval_clamp");
    chk(4'd0, 1'b1, 1'b0, "clamp_then_wrap");

    // Limit lowered under a running count
    bus.limit = 4'd15; bus.load = 1'b1; bus.load_val = 4'd12;
    chk(4'd12, 1'b0, 1'b0, "load12");
    bus.load = 1'b0; bus.limit = 4'd6; bus.up = 1'b0;
    chk(4'd6, 1'b0, 1'b0, "limit_drop_clamp");
    chk(4'd5, 1'b0, 1'b0, "after_clamp_down");

    // Direction change takes effect on the same edge
    bus.up = 1'b1;
    chk(4'd6, 1'b0, 1'b0, "dir_up");
    bus.up = 1'b0;
    chk(4'd5, 1'b0, 1'b0, "dir_down");

    // Saturate at the bottom
    bus.sat = 1'b1; bus.limit = 4'd9; bus.load = 1'b1; bus.load_val = 4'd1;
    chk(4'd1, 1'b0, 1'b0, "load1");
    bus.load = 1'b0;
    chk(4'd0, 1'b0, 1'b0, "sat_down0");
    chk(4'd0, 1'b1, 1'b0, "sat_bottom");
    chk(4'd0, 1'b1, 1'b0, "sat_bottom2");

    // limit == 0: every enabled cycle is a boundary
    bus.sat = 1'b0; bus.limit = 4'd0; bus.load = 1'b1; bus.load_val = 4'd5;
    chk(4'd0, 1'b0, 1'b0, "lim0_load");
    bus.load = 1'b0; bus.up = 1'b1;
    chk(4'd0, 1'b1, 1'b0, "lim0_up");
    bus.up = 1'b0;
    chk(4'd0, 1'b1, 1'b0, "lim0_down");

    // Drain and confirm every expectation was consumed
    repeat (3) @(negedge clk);
    checks++;
    if (exp_count_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_count_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
